// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one imem request at a time, tracks the PC with
// branch prediction and redirects, and presents the fetched word to the IF/ID stage.
module ifu_fetch #(
    parameter logic [31:0] PC_RESET_ADDR = 32'h8000_0000,
    parameter logic [31:0] INST_NOP      = 32'h0000_0013,
    parameter int unsigned TRAP_LEN      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid_i,
    input  logic [31:0]         redirect_pc_i,
    input  logic                stall_i,
    input  logic                bpu_taken_i,
    input  logic [31:0]         bpu_target_i,
    output logic                imem_req_valid_o,
    output logic [31:0]         imem_req_addr_o,
    input  logic                imem_req_ready_i,
    input  logic                imem_resp_valid_i,
    input  logic [31:0]         imem_resp_data_i,
    input  logic                imem_resp_err_i,
    output logic                inst_valid_o,
    output logic [31:0]         inst_addr_if_o,
    output logic [31:0]         inst_data_if_o,
    output logic                bpu_taken_if_o,
    output logic [TRAP_LEN-1:0] trap_bus_if_o
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state, state_nx;
    logic [XLEN-1:0]   pc, pc_nx;
    logic              drop, drop_nx;
    logic              pred_taken, pred_taken_nx;
    logic [XLEN-1:0]   pred_target, pred_target_nx;
    logic [XLEN-1:0]   inst_data, inst_data_nx;
    logic [1:0]        trap, trap_nx;
    logic              aligned;

    assign aligned = (pc[1:0] == 2'b00);

    // All state lives here; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= PC_RESET_ADDR;
            drop        <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            inst_data   <= INST_NOP;
            trap        <= 2'b00;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            drop        <= drop_nx;
            pred_taken  <= pred_taken_nx;
            pred_target <= pred_target_nx;
            inst_data   <= inst_data_nx;
            trap        <= trap_nx;
        end
    end

    // Next-state logic; a redirect outranks every other event.
    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        drop_nx        = drop;
        pred_taken_nx  = pred_taken;
        pred_target_nx = pred_target;
        inst_data_nx   = inst_data;
        trap_nx        = trap;
        unique case (state)
            IDLE: state_nx = REQ;
            REQ: begin
                if (redirect_valid_i) begin
                    pc_nx = redirect_pc_i;
                    if (aligned && imem_req_ready_i) begin
                        drop_nx  = 1'b1;
                        state_nx = WAIT;
                    end
                end else if (!aligned) begin
                    inst_data_nx  = INST_NOP;
                    trap_nx       = 2'b01;
                    pred_taken_nx = 1'b0;
                    state_nx      = DONE;
                end else if (imem_req_ready_i) begin
                    pred_taken_nx  = bpu_taken_i;
                    pred_target_nx = bpu_target_i;
                    state_nx       = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid_i) begin
                    pc_nx = redirect_pc_i;
                    if (imem_resp_valid_i) begin
                        drop_nx  = 1'b0;
                        state_nx = REQ;
                    end else begin
                        drop_nx = 1'b1;
                    end
                end else if (imem_resp_valid_i) begin
                    if (drop) begin
                        drop_nx  = 1'b0;
                        state_nx = REQ;
                    end else begin
                        inst_data_nx = imem_resp_err_i ? INST_NOP : imem_resp_data_i;
                        trap_nx      = {imem_resp_err_i, 1'b0};
                        state_nx     = DONE;
                    end
                end
            end
            DONE: begin
                if (redirect_valid_i) begin
                    pc_nx    = redirect_pc_i;
                    state_nx = REQ;
                end else if (!stall_i) begin
                    pc_nx    = pred_taken ? pred_target : pc + XLEN'(4);
                    state_nx = REQ;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode only registered state, so reset clears them immediately.
    always_comb begin
        imem_req_valid_o = (state == REQ) && aligned;
        imem_req_addr_o  = pc;
        inst_valid_o     = (state == DONE);
        inst_addr_if_o   = PC_RESET_ADDR - XLEN'(4);
        inst_data_if_o   = INST_NOP;
        bpu_taken_if_o   = 1'b0;
        trap_bus_if_o    = '0;
        if (state == DONE) begin
            inst_addr_if_o = pc;
            inst_data_if_o = inst_data;
            bpu_taken_if_o = pred_taken;
            trap_bus_if_o  = TRAP_LEN'(trap);
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch: nominal fetch, stall, prediction,
// redirect-drop, misaligned trap, access fault and asynchronous reset.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        bpu_taken;
    logic [31:0] bpu_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        bpu_taken_if;
    logic [31:0] trap_bus;

    int total = 0;
    int fails = 0;

    ifu_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .redirect_valid_i  (redirect_valid),
        .redirect_pc_i     (redirect_pc),
        .stall_i           (stall),
        .bpu_taken_i       (bpu_taken),
        .bpu_target_i      (bpu_target),
        .imem_req_valid_o  (imem_req_valid),
        .imem_req_addr_o   (imem_req_addr),
        .imem_req_ready_i  (imem_req_ready),
        .imem_resp_valid_i (imem_resp_valid),
        .imem_resp_data_i  (imem_resp_data),
        .imem_resp_err_i   (imem_resp_err),
        .inst_valid_o      (inst_valid),
        .inst_addr_if_o    (inst_addr),
        .inst_data_if_o    (inst_data),
        .bpu_taken_if_o    (bpu_taken_if),
        .trap_bus_if_o     (trap_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_addr"},  inst_addr,       32'h7FFF_FFFC);
        chk({tag, "_data"},  inst_data,       32'h0000_0013);
        chk({tag, "_taken"}, 32'(bpu_taken_if), 32'd0);
        chk({tag, "_trap"},  trap_bus,        32'd0);
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
        bpu_taken = 1'b0; bpu_target = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        imem_resp_data = '0; imem_resp_err = 1'b0;

        // Reset values
        cyc(); cyc();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk_bubble("rst");
        rst = 1'b0;

        // Nominal fetch: IDLE -> REQ
        cyc();
        chk("nom_req_valid", 32'(imem_req_valid), 32'd1);
        chk("nom_req_addr", imem_req_addr, 32'h8000_0000);
        imem_req_ready = 1'b1;
        cyc();
        chk("nom_wait_req", 32'(imem_req_valid), 32'd0);
        chk("nom_wait_valid", 32'(inst_valid), 32'd0);
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
        cyc();
        chk("nom_valid", 32'(inst_valid), 32'd1);
        chk("nom_addr", inst_addr, 32'h8000_0000);
        chk("nom_data", inst_data, 32'h0050_0093);
        chk("nom_trap", trap_bus, 32'd0);
        chk("nom_taken", 32'(bpu_taken_if), 32'd0);
        imem_resp_valid = 1'b0; imem_resp_data = 32'hFFFF_FFFF;

        // Stall holds DONE outputs for 3 cycles
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_addr", inst_addr, 32'h8000_0000);
            chk("stall_data", inst_data, 32'h0050_0093);
            chk("stall_req", 32'(imem_req_valid), 32'd0);
        end
        stall = 1'b0;
        cyc();
        chk("seq_req_valid", 32'(imem_req_valid), 32'd1);
        chk("seq_req_addr", imem_req_addr, 32'h8000_0004);
        chk_bubble("seq");

        // Taken prediction sampled at handshake
        imem_req_ready = 1'b1; bpu_taken = 1'b1; bpu_target = 32'h8000_0100;
        cyc();
        imem_req_ready = 1'b0; bpu_taken = 1'b0; bpu_target = 32'h1234_5678;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0113;
        cyc();
        imem_resp_valid = 1'b0;
        chk("bp_valid", 32'(inst_valid), 32'd1);
        chk("bp_taken", 32'(bpu_taken_if), 32'd1);
        chk("bp_addr", inst_addr, 32'h8000_0004);
        chk("bp_data", inst_data, 32'h0010_0113);
        cyc();
        chk("bp_req_addr", imem_req_addr, 32'h8000_0100);
        chk("bp_req_valid", 32'(imem_req_valid), 32'd1);

        // Redirect in WAIT; late response is dropped
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        cyc();
        redirect_valid = 1'b0;
        chk("rd_wait_valid", 32'(inst_valid), 32'd0);
        chk("rd_wait_req", 32'(imem_req_valid), 32'd0);
        cyc();
        chk("rd_wait2_valid", 32'(inst_valid), 32'd0);
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_0001;
        cyc();
        imem_resp_valid = 1'b0;
        chk("rd_drop_valid", 32'(inst_valid), 32'd0);
        chk("rd_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rd_req_addr", imem_req_addr, 32'h8000_0200);

        // Redirect to misaligned PC: no request, fetch-misaligned trap
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0202;
        cyc();
        redirect_valid = 1'b0;
        chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
        cyc();
        chk("mis_valid", 32'(inst_valid), 32'd1);
        chk("mis_trap", trap_bus, 32'd1);
        chk("mis_data", inst_data, 32'h0000_0013);
        chk("mis_addr", inst_addr, 32'h8000_0202);
        chk("mis_taken", 32'(bpu_taken_if), 32'd0);
        chk("mis_req_valid2", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
        cyc();
        redirect_valid = 1'b0;
        chk("rdd_valid", 32'(inst_valid), 32'd0);
        chk("rdd_req_addr", imem_req_addr, 32'h8000_0300);

        // Access fault
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_err = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        cyc();
        imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
        chk("err_valid", 32'(inst_valid), 32'd1);
        chk("err_trap", trap_bus, 32'd2);
        chk("err_data", inst_data, 32'h0000_0013);
        chk("err_addr", inst_addr, 32'h8000_0300);
        cyc();
        chk("err_next_addr", imem_req_addr, 32'h8000_0304);

        // Asynchronous reset while WAIT
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
        chk_bubble("arst");
        imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_BAD0;
        cyc();
        rst = 1'b0;
        cyc();
        chk("late_req_addr", imem_req_addr, 32'h8000_0000);
        chk("late_req_valid", 32'(imem_req_valid), 32'd1);
        chk("late_valid", 32'(inst_valid), 32'd0);
        cyc();
        imem_resp_valid = 1'b0;
        chk("late2_valid", 32'(inst_valid), 32'd0);
        chk("late2_req_addr", imem_req_addr, 32'h8000_0000);

        // Asynchronous reset drops a pending request mid-cycle
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0400;
        cyc();
        redirect_valid = 1'b0;
        chk("pre_arst_addr", imem_req_addr, 32'h8000_0400);
        #2 rst = 1'b1;
        #1;
        chk("arst2_req_valid", 32'(imem_req_valid), 32'd0);
        chk("arst2_req_addr", imem_req_addr, 32'h8000_0000);
        cyc();
        rst = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
